// File: rtl/mul_hilo_ctrl_if.sv
// Request/response channel between the EX stage (master) and the HI/LO multiply sequencer (slave).
interface mul_hilo_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Single-outstanding sequencer for the pipelined multiplier; owns the architectural HI/LO pair.
// Multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) are built only when MUL_ACCUM_EN is defined.
module mul_hilo_ctrl #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  mul_hilo_ctrl_if.slave req,
  input  logic           flush,
  output logic           mul_start,
  output logic           mul_sign,
  output logic [31:0]    mul_a,
  output logic [31:0]    mul_b,
  input  logic [63:0]    mul_result,
  output logic [31:0]    hi,
  output logic [31:0]    lo,
  output logic           busy
);

  localparam int unsigned CNT_W = $clog2(MUL_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MFHI  = 4'd9;
  localparam logic [3:0] OP_MFLO  = 4'd10;

`ifdef MUL_ACCUM_EN
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1
  } state_t;
`endif

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [3:0]         op_r;
  logic [31:0]        hi_r;
  logic [31:0]        lo_r;
  logic [31:0]        mul_a_r;
  logic [31:0]        mul_b_r;
  logic               mul_sign_r;
  logic               mul_start_r;
  logic               resp_valid_r;
  logic [31:0]        resp_data_r;
`ifdef MUL_ACCUM_EN
  logic [63:0]        prod_r;
`endif

  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MUL_ACCUM_EN
    return (op <= OP_MSUBU);
`else
    return (op <= OP_MUL);
`endif
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    logic s;
    s = (op == OP_MULT) || (op == OP_MUL);
`ifdef MUL_ACCUM_EN
    s = s || (op == OP_MADD) || (op == OP_MSUB);
`endif
    return s;
  endfunction

  assign req.req_ready  = (state_r == ST_IDLE) && !flush && !reset;
  assign req.resp_valid = resp_valid_r;
  assign req.resp_data  = resp_data_r;
  assign mul_start      = mul_start_r;
  assign mul_sign       = mul_sign_r;
  assign mul_a          = mul_a_r;
  assign mul_b          = mul_b_r;
  assign hi             = hi_r;
  assign lo             = lo_r;
  assign busy           = (state_r != ST_IDLE);

  // Sequencer FSM: op accept, latency count, product capture and HI/LO update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_W'(0);
      op_r         <= 4'd0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      mul_a_r      <= 32'd0;
      mul_b_r      <= 32'd0;
      mul_sign_r   <= 1'b0;
      mul_start_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'd0;
`ifdef MUL_ACCUM_EN
      prod_r       <= 64'd0;
`endif
    end else begin
      mul_start_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      if (flush) begin
        // Abort whatever is in flight; operands stay as they were.
        state_r <= ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (req.req_valid) begin
              case (req.req_op)
                OP_MTHI: hi_r <= req.req_a;
                OP_MTLO: lo_r <= req.req_a;
                OP_MFHI: begin
                  resp_data_r  <= hi_r;
                  resp_valid_r <= 1'b1;
                end
                OP_MFLO: begin
                  resp_data_r  <= lo_r;
                  resp_valid_r <= 1'b1;
                end
                default: begin
                  if (is_mul_op(req.req_op)) begin
                    op_r        <= req.req_op;
                    mul_a_r     <= req.req_a;
                    mul_b_r     <= req.req_b;
                    mul_sign_r  <= is_signed_op(req.req_op);
                    mul_start_r <= 1'b1;
                    cnt_r       <= CNT_W'(MUL_LAT);
                    state_r     <= ST_WAIT;
                  end else begin
                    state_r <= ST_IDLE;
                  end
                end
              endcase
            end else begin
              state_r <= ST_IDLE;
            end
          end

          ST_WAIT: begin
            if (cnt_r == CNT_W'(0)) begin
              case (op_r)
                OP_MULT, OP_MULTU: begin
                  {hi_r, lo_r} <= mul_result;
                  state_r      <= ST_IDLE;
                end
                OP_MUL: begin
                  resp_data_r  <= mul_result[31:0];
                  resp_valid_r <= 1'b1;
                  state_r      <= ST_IDLE;
                end
`ifdef MUL_ACCUM_EN
                default: begin
                  // Register the product so the 64-bit accumulate sits in its own cycle.
                  prod_r  <= mul_result;
                  state_r <= ST_ACC;
                end
`else
                default: state_r <= ST_IDLE;
`endif
              endcase
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end

`ifdef MUL_ACCUM_EN
          ST_ACC: begin
            if ((op_r == OP_MSUB) || (op_r == OP_MSUBU)) begin
              {hi_r, lo_r} <= {hi_r, lo_r} - prod_r;
            end else begin
              {hi_r, lo_r} <= {hi_r, lo_r} + prod_r;
            end
            state_r <= ST_IDLE;
          end
`endif

          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: response scoreboard plus direct HI/LO and control checks.
module tb_mul_hilo_ctrl;
  localparam int unsigned MUL_LAT = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        mul_start;
  logic        mul_sign;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [63:0] pipe [MUL_LAT];

  mul_hilo_ctrl_if bus();

  mul_hilo_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (bus.slave),
    .flush      (flush),
    .mul_start  (mul_start),
    .mul_sign   (mul_sign),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Multiplier model with MUL_LAT register stages.
  always @(posedge clk) begin
    if (mul_sign)
      pipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    else
      pipe[0] <= {32'd0, mul_a} * {32'd0, mul_b};
    for (int i = 1; i < MUL_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mul_result = pipe[MUL_LAT-1];

  // Monitor: each resp_valid cycle consumes one expected response.
  always @(negedge clk) begin
    if (bus.resp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected got %h want none", bus.resp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.resp_data !== mon_exp) begin
          errors++;
          $display("FAIL resp_data got %h want %h", bus.resp_data, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for acceptance, return the number of stalled cycles.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    stalls = 0;
    @(negedge clk);
    while (!bus.req_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout got stalled want accept op %0d", op);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;

    // Reset state
    cycles(3);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_ctrl", {60'd0, mul_start, mul_sign, bus.resp_valid, busy}, 64'd0);
    check("rst_resp_data", 64'(bus.resp_data), 64'd0);
    reset = 1'b0;
    #1;
    check("idle_ready", 64'(bus.req_ready), 64'd1);

    // MULT / MULTU
    issue(4'd0, 32'hFFFF_FFFF, 32'd2, st);
    check("mult_start", {61'd0, mul_start, mul_sign, busy}, 64'h7);
    check("mult_opnd", {mul_a, mul_b}, {32'hFFFF_FFFF, 32'd2});
    check("mult_ready_low", 64'(bus.req_ready), 64'd0);
    cycles(1);
    check("start_pulse", 64'(mul_start), 64'd0);
    cycles(MUL_LAT);
    check("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
    check("mult_idle", 64'(busy), 64'd0);
    issue(4'd1, 32'hFFFF_FFFF, 32'd2, st);
    check("multu_sign", 64'(mul_sign), 64'd0);
    cycles(MUL_LAT + 1);
    check("multu_hilo", {hi, lo}, {32'h0000_0001, 32'hFFFF_FFFE});

    // MUL: response only, HI/LO untouched
    exp_q.push_back(32'h0001_0000);
    issue(4'd2, 32'h0001_0000, 32'h0001_0001, st);
    cycles(MUL_LAT + 2);
    check("mul_hilo_keep", {hi, lo}, {32'h0000_0001, 32'hFFFF_FFFE});

    // MFHI / MFLO back-to-back
    exp_q.push_back(32'h0000_0001);
    issue(4'd9, 32'd0, 32'd0, st);
    exp_q.push_back(32'hFFFF_FFFE);
    issue(4'd10, 32'd0, 32'd0, st);
    check("mf_no_stall", 64'(st), 64'd0);
    cycles(1);

    // Accumulate ops (no-ops without MUL_ACCUM_EN)
    issue(4'd7, 32'd5, 32'd0, st);
    issue(4'd8, 32'd7, 32'd0, st);
    check("mthi_mtlo", {hi, lo}, {32'd5, 32'd7});
    issue(4'd3, 32'd3, 32'd4, st);
    cycles(MUL_LAT + 2);
`ifdef MUL_ACCUM_EN
    check("madd_hilo", {hi, lo}, {32'd5, 32'h13});
`else
    check("madd_noop", {hi, lo}, {32'd5, 32'd7});
`endif
    check("madd_idle", 64'(busy), 64'd0);
    issue(4'd7, 32'd0, 32'd0, st);
    issue(4'd8, 32'd0, 32'd0, st);
    issue(4'd6, 32'd1, 32'd1, st);
    cycles(MUL_LAT + 2);
`ifdef MUL_ACCUM_EN
    check("msubu_wrap", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("msubu_noop", {hi, lo}, 64'd0);
`endif
    issue(4'd4, 32'd1, 32'd1, st);
    cycles(MUL_LAT + 2);
    check("maddu_wrap", {hi, lo}, 64'd0);

    // Reserved op: accepted, no effect
    issue(4'd12, 32'hDEAD_BEEF, 32'd3, st);
    check("rsvd_idle", 64'(busy), 64'd0);
    cycles(2);
    check("rsvd_hilo", {hi, lo}, 64'd0);

    // MFLO right after MULT stalls until the product lands
    issue(4'd0, 32'd3, 32'd5, st);
    exp_q.push_back(32'd15);
    issue(4'd10, 32'd0, 32'd0, st);
    check("mflo_stalls", 64'(st), 64'(MUL_LAT + 1));
    check("mult35_hilo", {hi, lo}, {32'd0, 32'd15});
    cycles(1);

    // Flush of in-flight ops
    issue(4'd7, 32'hA, 32'd0, st);
    issue(4'd8, 32'hB, 32'd0, st);
    issue(4'd0, 32'd2, 32'd3, st);
    flush = 1'b1;
    #1;
    check("flush_ready_low", 64'(bus.req_ready), 64'd0);
    cycles(1);
    flush = 1'b0;
    #1;
    check("flush_idle", {62'd0, busy, bus.req_ready}, 64'd1);
    cycles(3);
    check("flush_mult_hilo", {hi, lo}, {32'hA, 32'hB});
    issue(4'd2, 32'd2, 32'd3, st);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    cycles(3);
    issue(4'd3, 32'd1, 32'd1, st);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    #1;
    check("flush_madd_ready", 64'(bus.req_ready), 64'd1);
    cycles(3);
    check("flush_madd_hilo", {hi, lo}, {32'hA, 32'hB});
    bus.req_valid = 1'b1;
    bus.req_op    = 4'd7;
    bus.req_a     = 32'h99;
    flush = 1'b1;
    cycles(1);
    bus.req_valid = 1'b0;
    flush = 1'b0;
    check("flush_blocks_accept", 64'(hi), 64'hA);

    // Reset during WAIT
    issue(4'd0, 32'd7, 32'd7, st);
    reset = 1'b1;
    cycles(1);
    check("rst_wait_hilo", {hi, lo}, 64'd0);
    check("rst_wait_ctrl", {61'd0, busy, bus.resp_valid, mul_start}, 64'd0);
    check("rst_wait_opnd", {mul_a, mul_b}, 64'd0);
    reset = 1'b0;
    cycles(MUL_LAT + 3);
    check("rst_wait_no_capture", {hi, lo}, 64'd0);

    cycles(2);
    check("resp_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
